// File: rtl/orion_join_pkg.sv
// Shared constants, state type and slicing helper for the orion clocked join.
package orion_join_pkg;

  localparam int unsigned ACK_DECOUPLED = 0;
  localparam int unsigned ACK_COUPLED   = 1;

  typedef enum logic {
    IDLE     = 1'b0,
    OUT_WAIT = 1'b1
  } join_state_e;

  // Low bit index of channel ch in a packed bus of width-bit channels.
  function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/orion_sync_bit.sv
// STAGES-deep synchroniser for one phase bit; depth 0 is a plain wire.
module orion_sync_bit #(
  parameter int unsigned STAGES = 2,
  parameter logic        P_INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      logic [STAGES-1:0] chain_q;
      logic [STAGES-1:0] chain_d;

      // Shift the incoming bit one stage further down the chain.
      always_comb begin
        chain_d    = chain_q;
        chain_d[0] = d;
        for (int unsigned i = 1; i < STAGES; i++) begin
          chain_d[i] = chain_q[i-1];
        end
      end

      // Chain register, reset to the idle phase.
      always_ff @(posedge clk) begin
        if (reset) begin
          chain_q <= {STAGES{P_INIT}};
        end else begin
          chain_q <= chain_d;
        end
      end

      assign q = chain_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/orion_join_sync.sv
// Clocked NUM_IN-way two-phase join with optional input synchronisers and
// selectable decoupled/coupled input acknowledge.
module orion_join_sync
  import orion_join_pkg::*;
#(
  parameter int unsigned NUM_IN      = 2,
  parameter int unsigned DATA_W      = 8,
  parameter logic        P_INIT      = 1'b0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_MODE    = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_req,
  output logic [NUM_IN-1:0]        in_ack,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic                     out_req,
  input  logic                     out_ack,
  output logic [NUM_IN*DATA_W-1:0] out_data,
  output logic                     busy,
  output logic [CNT_W-1:0]         join_count
);

  logic [NUM_IN-1:0] s_req;
  logic              s_ack;

  generate
    for (genvar i = 0; i < NUM_IN; i++) begin : g_req_sync
      orion_sync_bit #(
        .STAGES (SYNC_STAGES),
        .P_INIT (P_INIT)
      ) u_sync_req (
        .clk   (clk),
        .reset (reset),
        .d     (in_req[i]),
        .q     (s_req[i])
      );
    end
  endgenerate

  orion_sync_bit #(
    .STAGES (SYNC_STAGES),
    .P_INIT (P_INIT)
  ) u_sync_ack (
    .clk   (clk),
    .reset (reset),
    .d     (out_ack),
    .q     (s_ack)
  );

  join_state_e               state_q, state_d;
  logic                      out_req_q, out_req_d;
  logic [NUM_IN-1:0]         in_ack_q, in_ack_d;
  logic [NUM_IN*DATA_W-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0]          join_count_q, join_count_d;

  logic [NUM_IN-1:0] pend;
  logic              all_pend;
  logic              out_free;
  logic              fire;

  // Join condition, data capture, phase toggles and state transitions.
  always_comb begin
    pend     = s_req ^ in_ack_q;
    all_pend = &pend;
    out_free = (out_req_q == s_ack);

    if (ACK_MODE == ACK_COUPLED) begin
      fire = all_pend & out_free & (state_q == IDLE);
    end else begin
      fire = all_pend & out_free;
    end

    state_d      = state_q;
    out_req_d    = out_req_q;
    in_ack_d     = in_ack_q;
    out_data_d   = out_data_q;
    join_count_d = join_count_q;

    if (fire) begin
      for (int unsigned ch = 0; ch < NUM_IN; ch++) begin
        out_data_d[chan_lsb(ch, DATA_W) +: DATA_W] = in_data[chan_lsb(ch, DATA_W) +: DATA_W];
      end
      out_req_d    = ~out_req_q;
      join_count_d = join_count_q + CNT_W'(1);
      state_d      = OUT_WAIT;
      if (ACK_MODE != ACK_COUPLED) begin
        in_ack_d = ~in_ack_q;
      end
    end else if ((state_q == OUT_WAIT) && out_free) begin
      // In coupled mode the inputs are only released once the output ack is back.
      state_d = IDLE;
      if (ACK_MODE == ACK_COUPLED) begin
        in_ack_d = ~in_ack_q;
      end
    end
  end

  // State and phase registers; reset discards any outstanding token.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      out_req_q    <= P_INIT;
      in_ack_q     <= {NUM_IN{P_INIT}};
      out_data_q   <= '0;
      join_count_q <= '0;
    end else begin
      state_q      <= state_d;
      out_req_q    <= out_req_d;
      in_ack_q     <= in_ack_d;
      out_data_q   <= out_data_d;
      join_count_q <= join_count_d;
    end
  end

  assign in_ack     = in_ack_q;
  assign out_req    = out_req_q;
  assign out_data   = out_data_q;
  assign join_count = join_count_q;
  assign busy       = (state_q == OUT_WAIT);

endmodule

// File: tb/tb_orion_join_sync.sv
// Self-checking bench for orion_join_sync: three instances cover decoupled
// (P_INIT=1, 2 sync stages), coupled (2 sync stages) and a 3-input unsynchronised
// join with a 4-bit counter.
module tb_orion_join_sync;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Decoupled instance
  logic [1:0]  d_req, d_ack;
  logic [15:0] d_data, d_out_data, d_cnt;
  logic        d_out_req, d_out_ack, d_busy;

  // Coupled instance
  logic [1:0]  c_req, c_ack;
  logic [15:0] c_data, c_out_data, c_cnt;
  logic        c_out_req, c_out_ack, c_busy;

  // Three-input, no synchroniser, 4-bit counter
  logic [2:0]  z_req, z_ack;
  logic [23:0] z_data, z_out_data;
  logic [3:0]  z_cnt;
  logic        z_out_req, z_out_ack, z_busy;

  // Reference model: token counts; phases follow from parity, count from modulo.
  int unsigned d_joins, c_joins, c_acked, z_joins;

  orion_join_sync #(
    .NUM_IN(2), .DATA_W(8), .P_INIT(1'b1), .SYNC_STAGES(2), .ACK_MODE(0), .CNT_W(16)
  ) u_dec (
    .clk(clk), .reset(reset), .in_req(d_req), .in_ack(d_ack), .in_data(d_data),
    .out_req(d_out_req), .out_ack(d_out_ack), .out_data(d_out_data),
    .busy(d_busy), .join_count(d_cnt)
  );

  orion_join_sync #(
    .NUM_IN(2), .DATA_W(8), .P_INIT(1'b0), .SYNC_STAGES(2), .ACK_MODE(1), .CNT_W(16)
  ) u_cpl (
    .clk(clk), .reset(reset), .in_req(c_req), .in_ack(c_ack), .in_data(c_data),
    .out_req(c_out_req), .out_ack(c_out_ack), .out_data(c_out_data),
    .busy(c_busy), .join_count(c_cnt)
  );

  orion_join_sync #(
    .NUM_IN(3), .DATA_W(8), .P_INIT(1'b0), .SYNC_STAGES(0), .ACK_MODE(0), .CNT_W(4)
  ) u_s0 (
    .clk(clk), .reset(reset), .in_req(z_req), .in_ack(z_ack), .in_data(z_data),
    .out_req(z_out_req), .out_ack(z_out_ack), .out_data(z_out_data),
    .busy(z_busy), .join_count(z_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    d_req = 2'b11; d_out_ack = 1'b1; d_data = '0;
    c_req = 2'b00; c_out_ack = 1'b0; c_data = '0;
    z_req = 3'b000; z_out_ack = 1'b0; z_data = '0;
    tick();
    tick();
    checks++; if (d_out_req !== 1'b1) begin errors++; $display("FAIL reset_out_req: got %0h expected 1", d_out_req); end
    checks++; if (d_ack !== 2'b11) begin errors++; $display("FAIL reset_in_ack: got %0h expected 3", d_ack); end
    checks++; if (d_out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", d_out_data); end
    checks++; if (d_cnt !== 16'd0) begin errors++; $display("FAIL reset_join_count: got %0d expected 0", d_cnt); end
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", d_busy); end
    checks++; if (c_out_req !== 1'b0 || c_ack !== 2'b00) begin errors++; $display("FAIL reset_cpl_phases: got req %0h ack %0h expected 0 0", c_out_req, c_ack); end
    reset = 1'b0;
    d_joins = 0; c_joins = 0; c_acked = 0; z_joins = 0;
    tick();
  endtask

  task automatic test_dec_join();
    d_data[7:0] = 8'hA5;
    d_req[0] = ~d_req[0];
    repeat (10) begin
      tick();
      checks++;
      if (d_out_req !== 1'b1 || d_busy !== 1'b0) begin
        errors++; $display("FAIL dec_partial_wait: got req %0h busy %0h expected 1 0", d_out_req, d_busy);
      end
    end
    d_data[15:8] = 8'h3C;
    d_req[1] = ~d_req[1];
    for (int e = 1; e <= 3; e++) begin
      tick();
      if (e < 3) begin
        checks++;
        if (d_out_req !== 1'b1 || d_ack !== 2'b11) begin
          errors++; $display("FAIL dec_early_fire: edge %0d got req %0h ack %0h expected 1 3", e, d_out_req, d_ack);
        end
      end
    end
    d_joins = 1;
    checks++; if (d_out_req !== 1'b0) begin errors++; $display("FAIL dec_out_req: got %0h expected 0", d_out_req); end
    checks++; if (d_out_data !== 16'h3CA5) begin errors++; $display("FAIL dec_out_data: got %0h expected 3ca5", d_out_data); end
    checks++; if (d_ack !== 2'b00) begin errors++; $display("FAIL dec_in_ack: got %0h expected 0", d_ack); end
    checks++; if (d_busy !== 1'b1) begin errors++; $display("FAIL dec_busy: got %0h expected 1", d_busy); end
    checks++; if (d_cnt !== 16'd1) begin errors++; $display("FAIL dec_count: got %0d expected 1", d_cnt); end
  endtask

  task automatic test_dec_overlap();
    d_data = 16'h2211;
    d_req = ~d_req;
    repeat (6) tick();
    checks++;
    if (d_cnt !== 16'd1 || d_out_req !== 1'b0 || d_ack !== 2'b00) begin
      errors++; $display("FAIL dec_overlap_hold: got cnt %0d req %0h ack %0h expected 1 0 0", d_cnt, d_out_req, d_ack);
    end
    checks++; if (d_out_data !== 16'h3CA5) begin errors++; $display("FAIL dec_data_stable: got %0h expected 3ca5", d_out_data); end
    d_out_ack = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      if (e < 3) begin
        checks++;
        if (d_out_req !== 1'b0) begin errors++; $display("FAIL dec_overlap_early: edge %0d got %0h expected 0", e, d_out_req); end
      end
    end
    d_joins = 2;
    checks++; if (d_out_req !== 1'b1 || d_ack !== 2'b11) begin errors++; $display("FAIL dec_overlap_phases: got req %0h ack %0h expected 1 3", d_out_req, d_ack); end
    checks++; if (d_out_data !== 16'h2211) begin errors++; $display("FAIL dec_overlap_data: got %0h expected 2211", d_out_data); end
    checks++; if (d_cnt !== 16'd2 || d_busy !== 1'b1) begin errors++; $display("FAIL dec_overlap_count: got cnt %0d busy %0h expected 2 1", d_cnt, d_busy); end
  endtask

  task automatic test_dec_random();
    logic [7:0]  b [2];
    logic [15:0] exp_data;
    logic        exp_req;
    int          first, gap;
    for (int n = 0; n < 8; n++) begin
      d_out_ack = 1'b1 ^ d_joins[0];
      repeat (3) tick();
      checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL dec_rand_idle: iter %0d got busy %0h expected 0", n, d_busy); end
      b[0] = 8'($urandom());
      b[1] = 8'($urandom());
      exp_data = {b[1], b[0]};
      exp_req  = 1'b1 ^ d_joins[0];
      first = int'($urandom_range(0, 1));
      d_data[first*8 +: 8] = b[first];
      d_req[first] = ~d_req[first];
      gap = int'($urandom_range(0, 4));
      for (int g = 0; g < gap; g++) begin
        tick();
        checks++;
        if (d_out_req !== exp_req) begin errors++; $display("FAIL dec_rand_partial: iter %0d got %0h expected %0h", n, d_out_req, exp_req); end
      end
      d_data[(1-first)*8 +: 8] = b[1-first];
      d_req[1-first] = ~d_req[1-first];
      for (int e = 1; e <= 3; e++) begin
        tick();
        if (e < 3) begin
          checks++;
          if (d_out_req !== exp_req) begin errors++; $display("FAIL dec_rand_early: iter %0d edge %0d got %0h expected %0h", n, e, d_out_req, exp_req); end
        end
      end
      d_joins++;
      checks++;
      if (d_out_req !== (1'b1 ^ d_joins[0]) || d_ack !== {2{1'b1 ^ d_joins[0]}} || d_out_data !== exp_data || d_cnt !== 16'(d_joins)) begin
        errors++;
        $display("FAIL dec_rand_fire: iter %0d got req %0h ack %0h data %0h cnt %0d expected %0h %0h %0h %0d",
                 n, d_out_req, d_ack, d_out_data, d_cnt, 1'b1 ^ d_joins[0], {2{1'b1 ^ d_joins[0]}}, exp_data, d_joins);
      end
    end
  endtask

  task automatic test_coupled();
    logic [15:0] exp_data;
    logic        exp_req;
    logic [1:0]  exp_ack;
    for (int n = 0; n < 4; n++) begin
      exp_data = 16'($urandom());
      exp_req  = c_joins[0];
      exp_ack  = {2{c_acked[0]}};
      c_data = exp_data;
      c_req[0] = ~c_req[0];
      repeat (int'($urandom_range(0, 3))) tick();
      c_req[1] = ~c_req[1];
      for (int e = 1; e <= 3; e++) begin
        tick();
        if (e < 3) begin
          checks++;
          if (c_out_req !== exp_req) begin errors++; $display("FAIL cpl_early: iter %0d edge %0d got %0h expected %0h", n, e, c_out_req, exp_req); end
        end
      end
      c_joins++;
      checks++;
      if (c_out_req !== c_joins[0] || c_out_data !== exp_data || c_busy !== 1'b1 || c_cnt !== 16'(c_joins)) begin
        errors++;
        $display("FAIL cpl_fire: iter %0d got req %0h data %0h busy %0h cnt %0d expected %0h %0h 1 %0d",
                 n, c_out_req, c_out_data, c_busy, c_cnt, c_joins[0], exp_data, c_joins);
      end
      checks++; if (c_ack !== exp_ack) begin errors++; $display("FAIL cpl_ack_held: iter %0d got %0h expected %0h", n, c_ack, exp_ack); end
      repeat (8) tick();
      checks++;
      if (c_cnt !== 16'(c_joins) || c_out_req !== c_joins[0] || c_ack !== exp_ack) begin
        errors++; $display("FAIL cpl_no_refire: iter %0d got cnt %0d req %0h ack %0h expected %0d %0h %0h", n, c_cnt, c_out_req, c_ack, c_joins, c_joins[0], exp_ack);
      end
      c_out_ack = c_joins[0];
      for (int e = 1; e <= 3; e++) begin
        tick();
        if (e < 3) begin
          checks++;
          if (c_ack !== exp_ack || c_busy !== 1'b1) begin errors++; $display("FAIL cpl_ack_early: iter %0d edge %0d got ack %0h busy %0h expected %0h 1", n, e, c_ack, c_busy, exp_ack); end
        end
      end
      c_acked++;
      checks++;
      if (c_ack !== {2{c_acked[0]}} || c_busy !== 1'b0) begin
        errors++; $display("FAIL cpl_ack_release: iter %0d got ack %0h busy %0h expected %0h 0", n, c_ack, c_busy, {2{c_acked[0]}});
      end
      repeat (4) tick();
      checks++; if (c_cnt !== 16'(c_joins)) begin errors++; $display("FAIL cpl_after_ack: iter %0d got cnt %0d expected %0d", n, c_cnt, c_joins); end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_data;
    for (int k = 0; k < 17; k++) begin
      exp_data = 24'($urandom());
      z_data = exp_data;
      z_req[1:0] = ~z_req[1:0];
      tick();
      checks++;
      if (z_out_req !== z_joins[0]) begin errors++; $display("FAIL b2b_partial: iter %0d got %0h expected %0h", k, z_out_req, z_joins[0]); end
      z_req[2] = ~z_req[2];
      z_out_ack = z_joins[0];
      tick();
      z_joins++;
      checks++;
      if (z_out_req !== z_joins[0] || z_ack !== {3{z_joins[0]}} || z_out_data !== exp_data ||
          z_cnt !== 4'(z_joins % 16) || z_busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_fire: iter %0d got req %0h ack %0h data %0h cnt %0d busy %0h expected %0h %0h %0h %0d 1",
                 k, z_out_req, z_ack, z_out_data, z_cnt, z_busy, z_joins[0], {3{z_joins[0]}}, exp_data, z_joins % 16);
      end
    end
    checks++; if (z_cnt !== 4'd1) begin errors++; $display("FAIL b2b_wrap: got %0d expected 1", z_cnt); end
  endtask

  task automatic test_reset_midop();
    checks++; if (d_busy !== 1'b1) begin errors++; $display("FAIL midop_precondition: got busy %0h expected 1", d_busy); end
    reset = 1'b1;
    d_req = 2'b11; d_out_ack = 1'b1;
    c_req = 2'b00; c_out_ack = 1'b0;
    z_req = 3'b000; z_out_ack = 1'b0;
    tick();
    checks++;
    if (d_busy !== 1'b0 || d_out_req !== 1'b1 || d_ack !== 2'b11 || d_cnt !== 16'd0 || d_out_data !== 16'h0000) begin
      errors++; $display("FAIL midop_reset: got busy %0h req %0h ack %0h cnt %0d data %0h expected 0 1 3 0 0", d_busy, d_out_req, d_ack, d_cnt, d_out_data);
    end
    reset = 1'b0;
    d_joins = 0;
    repeat (6) tick();
    checks++;
    if (d_out_req !== 1'b1 || d_cnt !== 16'd0 || d_busy !== 1'b0) begin
      errors++; $display("FAIL midop_phantom: got req %0h cnt %0d busy %0h expected 1 0 0", d_out_req, d_cnt, d_busy);
    end
  endtask

  initial begin
    test_reset();
    test_dec_join();
    test_dec_overlap();
    test_dec_random();
    test_coupled();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/orion_join_sync.md
Name: orion_join_sync

Overview:
- Clocked, parametrised successor to the two-input click join.
- Joins NUM_IN two-phase (transition-signalling) bundled-data input channels into one two-phase output channel carrying the concatenated data.
- Optional input-side synchronisers let it sit at the boundary between self-timed orion pipelines and the clocked fabric.
- Selectable acknowledge mode: decoupled (one-slot buffer) or coupled (acks follow the output ack, as in the asynchronous join).

Parameters:
- NUM_IN, 2, number of input channels (>=2).
- DATA_W, 8, data width per input channel.
- P_INIT, 0, reset phase of every req/ack phase register.
- SYNC_STAGES, 2, flop stages on each incoming req and on out_ack; 0 means inputs are already in the clk domain.
- ACK_MODE, 0, 0 = DECOUPLED (inputs acked on capture), 1 = COUPLED (inputs acked when the output ack returns).
- CNT_W, 16, width of the join event counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- in_req  input  NUM_IN  per-channel two-phase request
- in_ack  output  NUM_IN  per-channel two-phase acknowledge
- in_data  input  NUM_IN*DATA_W  bundled data; channel i occupies bits [i*DATA_W +: DATA_W]
- out_req  output  1  two-phase output request
- out_ack  input  1  two-phase output acknowledge
- out_data  output  NUM_IN*DATA_W  registered joined data, same packing as in_data
- busy  output  1  high while an output token is outstanding
- join_count  output  CNT_W  number of joins since reset

Behaviour:
- Interface decision: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - Synchroniser flops, out_req and every in_ack bit take P_INIT.
  - out_data, join_count and busy are 0.
- Synchronisation and pending flags:
  - s_req[i] is in_req[i] after SYNC_STAGES flops; s_ack is out_ack after SYNC_STAGES flops. With SYNC_STAGES=0 these are direct wires.
  - pend[i] = s_req[i] XOR in_ack[i].
  - out_free = (out_req == s_ack).
  - all_pend = AND of pend[]; partial arrival waits indefinitely, with no timeout.
- State machine:
  - IDLE: no output token outstanding.
  - OUT_WAIT: out_req != s_ack.
  - busy = (state == OUT_WAIT).
- DECOUPLED (ACK_MODE=0):
  - fire = all_pend & out_free. out_free includes the cycle in which s_ack matches out_req, so an input set arriving in the same cycle the output ack returns fires in that cycle.
  - On fire, in one edge: out_data <= in_data, out_req toggles, every in_ack bit toggles, join_count increments.
  - Inputs are freed immediately, so a second input set may become pending while OUT_WAIT; it fires once out_free.
- COUPLED (ACK_MODE=1):
  - fire = all_pend & out_free & (state == IDLE).
  - On fire: capture data, toggle out_req, increment join_count. in_ack is held.
  - When s_ack matches out_req in OUT_WAIT, every in_ack bit toggles and the state returns to IDLE.
  - The inputs are therefore still pending during OUT_WAIT but must not re-fire.
- Latency:
  - Last in_req toggle to out_req toggle is SYNC_STAGES+1 clk edges.
  - In DECOUPLED mode, in_ack toggles on the same edge as out_req.
  - In COUPLED mode, in_ack toggles SYNC_STAGES+1 edges after out_ack toggles.
- Data:
  - in_data must be stable while pend[i] is set.
  - in_data is captured unsynchronised; the req synchroniser delay provides the bundling margin.
  - out_data is stable while busy.
- join_count wraps modulo 2^CNT_W with no saturation.
- Reset mid-operation:
  - Outstanding tokens are discarded and all phases return to P_INIT.
  - The environment is also reset to P_INIT, so no phantom token appears.
- A double toggle on in_req before in_ack is a protocol violation; behaviour is undefined and no detection is required.

Decomposition:
- orion_join_pkg holds:
  - ACK_DECOUPLED / ACK_COUPLED constants;
  - state encoding IDLE/OUT_WAIT;
  - a helper function for the channel slice index.
- Sub-module orion_sync_bit: a SYNC_STAGES-deep flop chain with reset value P_INIT, passing through when depth is 0.
  - Instantiated NUM_IN times for in_req and once for out_ack.

Test Plan:
- Reset with P_INIT=1, SYNC_STAGES=2 -> out_req=1, in_ack=2'b11, out_data=0, join_count=0, busy=0.
- NUM_IN=2, ACK_MODE=0, SYNC_STAGES=2: toggle in_req[0] with data 8'hA5, wait 10 cycles, then toggle in_req[1] with data 8'h3C:
  - no output before in_req[1] toggles;
  - 3 edges after in_req[1] toggles, out_req toggles and out_data=16'h3CA5 (channel 1 in the upper byte);
  - in_ack toggles on that same edge, busy=1, join_count=1.
- ACK_MODE=0: present a second input set (data 8'h11/8'h22) while OUT_WAIT -> no fire until out_ack toggles; fire on the edge where s_ack matches; join_count=2.
- ACK_MODE=1: single join -> in_ack unchanged until out_ack toggles, then toggles 3 edges later; no second fire while the inputs remain pending.
- CNT_W=4: 17 back-to-back joins with SYNC_STAGES=0 -> join_count=1 after wrap; each out_req toggle comes 1 edge after the last input toggle.
- Assert reset while OUT_WAIT -> next edge: busy=0, out_req=in_ack=P_INIT, no spurious out_req toggle afterwards.
